// File: rtl/apb_pkg.sv
// Shared APB definitions: bus width defaults, FSM state encoding and
// response codes used by both the APB master and the memory completer.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic {
    APB_S_IDLE   = 1'b0,
    APB_S_ACCESS = 1'b1
  } apb_state_e;

  localparam logic APB_RESP_OKAY = 1'b0;
  localparam logic APB_RESP_ERR  = 1'b1;

  localparam int APB_MAX_WAIT = 15;

endpackage : apb_pkg

// File: rtl/apb_slave_mem_if.sv
// APB3 bus bundle between one requester and one completer; signal names
// follow the AMBA APB3 naming so waveforms read like the protocol document.
interface apb_slave_mem_if
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_W,
  parameter int DATA_WIDTH = APB_DATA_W
);

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface : apb_slave_mem_if

// File: rtl/apb_mem_array.sv
// DEPTH x WIDTH flop-based word store: one synchronous write port, one
// combinational read port, whole array cleared by the asynchronous reset.
module apb_mem_array #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array is built from flops, not a RAM macro, precisely so that
  // reset can clear every word; a RAM-inferred array must not be reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : apb_mem_array

// File: rtl/apb_slave_mem.sv
// APB3 completer fronting a word-addressed memory with a fixed number of
// wait states; out-of-range or misaligned accesses complete with PSLVERR.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = APB_ADDR_W,
  parameter int                    DATA_WIDTH  = APB_DATA_W,
  parameter int                    MEM_DEPTH   = 64,
  parameter int                    WAIT_STATES = 2,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic            PCLK,
  input  logic            PRESETn,
  apb_slave_mem_if.slave  apb
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(MEM_DEPTH);

  apb_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  err_q, err_d;

  logic                  setup_phase;
  logic                  access_phase;
  logic                  latch;
  logic                  complete;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Address decode on the live PADDR; its result is captured at setup.
  logic [ADDR_WIDTH-1:0] off;
  logic [ADDR_WIDTH-1:0] word_off;
  logic                  dec_err;
  logic [IDX_W-1:0]      dec_idx;

  always_comb begin
    off      = apb.PADDR - BASE_ADDR;
    word_off = off / ADDR_WIDTH'(BYTES);
    dec_idx  = word_off[IDX_W-1:0];
    dec_err  = (apb.PADDR < BASE_ADDR)
             | (word_off >= ADDR_WIDTH'(MEM_DEPTH))
             | ((off % ADDR_WIDTH'(BYTES)) != '0);
  end

  assign setup_phase  = apb.PSEL & ~apb.PENABLE;
  assign access_phase = apb.PSEL &  apb.PENABLE;

  // NOTE: every flop is assigned with <= so all registers sample the same
  // pre-edge values regardless of statement order.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= APB_S_IDLE;
      cnt_q    <= '0;
      pwrite_q <= 1'b0;
      wdata_q  <= '0;
      idx_q    <= '0;
      err_q    <= APB_RESP_OKAY;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pwrite_q <= pwrite_d;
      wdata_q  <= wdata_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
    end
  end

  // NOTE: each variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pwrite_d = pwrite_q;
    wdata_d  = wdata_q;
    idx_d    = idx_q;
    err_d    = err_q;
    latch    = 1'b0;

    unique case (state_q)
      APB_S_IDLE: begin
        if (setup_phase) begin
          latch   = 1'b1;
          state_d = APB_S_ACCESS;
        end
      end
      APB_S_ACCESS: begin
        if (access_phase) begin
          if (cnt_q != '0) cnt_d   = cnt_q - 4'd1;
          else             state_d = APB_S_IDLE;
        end else if (setup_phase) begin
          // Aborted transfer immediately replaced by a fresh setup phase.
          latch = 1'b1;
        end else begin
          state_d = APB_S_IDLE;
        end
      end
      default: state_d = APB_S_IDLE;
    endcase

    if (latch) begin
      pwrite_d = apb.PWRITE;
      wdata_d  = apb.PWDATA;
      idx_d    = dec_idx;
      err_d    = dec_err;
      cnt_d    = 4'(WAIT_STATES);
    end
  end

  always_comb begin
    complete    = (state_q == APB_S_ACCESS) & access_phase & (cnt_q == '0);
    mem_we      = complete & pwrite_q & (err_q == APB_RESP_OKAY);
    apb.PREADY  = complete;
    apb.PSLVERR = complete ? err_q : APB_RESP_OKAY;
    apb.PRDATA  = (complete & ~pwrite_q & (err_q == APB_RESP_OKAY)) ? mem_rdata : '0;
  end

  apb_mem_array #(
    .DEPTH (MEM_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .we_i    (mem_we),
    .waddr_i (idx_q),
    .wdata_i (wdata_q),
    .raddr_i (idx_q),
    .rdata_o (mem_rdata)
  );

endmodule : apb_slave_mem

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: two instances (2 and 0 wait states) driven by a
// task-level APB requester and compared against an array-based memory model.
module tb_apb_slave_mem;

  localparam int WS_A  = 2;
  localparam int WS_B  = 0;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [31:0] paddr   [2];
  logic [31:0] pwdata  [2];
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];

  apb_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_a ();
  apb_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_b ();

  assign bus_a.PSEL    = psel[0];
  assign bus_a.PENABLE = penable[0];
  assign bus_a.PWRITE  = pwrite[0];
  assign bus_a.PADDR   = paddr[0];
  assign bus_a.PWDATA  = pwdata[0];
  assign prdata[0]     = bus_a.PRDATA;
  assign pready[0]     = bus_a.PREADY;
  assign pslverr[0]    = bus_a.PSLVERR;

  assign bus_b.PSEL    = psel[1];
  assign bus_b.PENABLE = penable[1];
  assign bus_b.PWRITE  = pwrite[1];
  assign bus_b.PADDR   = paddr[1];
  assign bus_b.PWDATA  = pwdata[1];
  assign prdata[1]     = bus_b.PRDATA;
  assign pready[1]     = bus_b.PREADY;
  assign pslverr[1]    = bus_b.PSLVERR;

  apb_slave_mem #(.MEM_DEPTH(DEPTH), .WAIT_STATES(WS_A)) u_dut_a (
    .PCLK(clk), .PRESETn(rst_n), .apb(bus_a.slave)
  );
  apb_slave_mem #(.MEM_DEPTH(DEPTH), .WAIT_STATES(WS_B)) u_dut_b (
    .PCLK(clk), .PRESETn(rst_n), .apb(bus_b.slave)
  );

  int          checks = 0;
  int          errors = 0;
  int          ws [2];
  logic [31:0] model [2][DEPTH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH; i++) model[d][i] = '0;
  endtask

  task automatic go_idle(input int d);
    @(negedge clk);
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
  endtask

  // One complete transfer; a following call starts its setup phase on the very
  // next cycle, so consecutive calls are back-to-back.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input string tag);
    bit          err;
    logic [31:0] exp_rd;
    int          cyc;
    err    = (addr / 4 >= DEPTH) || (addr % 4 != 0);
    exp_rd = (!wr && !err) ? model[d][addr / 4] : 32'h0;

    @(negedge clk);
    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    pwrite[d]  = wr;
    paddr[d]   = addr;
    pwdata[d]  = wdata;

    @(negedge clk);
    penable[d] = 1'b1;
    paddr[d]   = $urandom;   // must be ignored: latched copy is used
    pwdata[d]  = $urandom;
    cyc = 1;
    #1;
    while (!pready[d] && cyc < 20) begin
      @(negedge clk);
      cyc++;
      #1;
    end
    check({tag, "_lat"}, cyc, ws[d] + 1);
    check({tag, "_err"}, {31'b0, pslverr[d]}, {31'b0, err});
    check({tag, "_rd"},  prdata[d], exp_rd);
    if (wr && !err) model[d][addr / 4] = wdata;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, finish required");
    $fatal(1, "watchdog");
  end

  initial begin
    ws[0] = WS_A;
    ws[1] = WS_B;
    clear_model();
    for (int d = 0; d < 2; d++) begin
      psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = '0;  pwdata[d]  = '0;
    end

    // Reset state.
    rst_n = 1'b0;
    #3;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst%0d_ready", d), {31'b0, pready[d]}, 32'h0);
      check($sformatf("rst%0d_err", d),   {31'b0, pslverr[d]}, 32'h0);
      check($sformatf("rst%0d_rdata", d), prdata[d], 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Two wait states: write then read back.
    xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, "ws2_wr08");
    xfer(0, 1'b0, 32'h08, 32'h0,        "ws2_rd08");
    go_idle(0);

    // Zero wait states, back-to-back.
    xfer(1, 1'b1, 32'h00, 32'h11223344, "ws0_wr00");
    xfer(1, 1'b1, 32'h04, 32'h55667788, "ws0_wr04");
    xfer(1, 1'b0, 32'h00, 32'h0,        "ws0_rd00");
    xfer(1, 1'b0, 32'h04, 32'h0,        "ws0_rd04");
    go_idle(1);

    // Error responses leave memory intact.
    xfer(0, 1'b1, 32'h04,  32'hCAFEF00D, "err_pre04");
    xfer(0, 1'b0, 32'h100, 32'h0,        "err_rd100");
    xfer(0, 1'b1, 32'h06,  32'hBADBAD00, "err_wr06");
    xfer(0, 1'b1, 32'hFC,  32'h0BADF00D, "err_wrFC_last");
    xfer(0, 1'b0, 32'h04,  32'h0,        "err_rd04");
    xfer(0, 1'b0, 32'hFC,  32'h0,        "err_rdFC");
    go_idle(0);

    // Abort a write after one wait cycle.
    xfer(0, 1'b1, 32'h10, 32'hA5A5A5A5, "abt_pre10");
    go_idle(0);
    @(negedge clk);
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
    paddr[0] = 32'h10; pwdata[0] = 32'h5A5A5A5A;
    @(negedge clk);
    penable[0] = 1'b1;
    #1 check("abt_wait1", {31'b0, pready[0]}, 32'h0);
    @(negedge clk);
    psel[0] = 1'b0; penable[0] = 1'b0;
    #1 check("abt_drop", {31'b0, pready[0]}, 32'h0);
    @(negedge clk);
    psel[0] = 1'b1; penable[0] = 1'b1;   // stray access strobe with FSM idle
    #1 check("abt_idle", {31'b0, pready[0]}, 32'h0);
    go_idle(0);
    xfer(0, 1'b0, 32'h10, 32'h0, "abt_rd10");
    go_idle(0);

    // Randomized traffic, mostly legal, some out-of-range or misaligned.
    for (int i = 0; i < 60; i++) begin
      int          d;
      logic [31:0] a;
      d = i % 2;
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 32'h11F);
      else                           a = $urandom_range(0, DEPTH - 1) * 4;
      xfer(d, 1'($urandom_range(0, 1)), a, $urandom, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 2) == 0) go_idle(d);
    end
    go_idle(0);
    go_idle(1);

    // Alternating write/read pairs, held back-to-back.
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a;
      a = $urandom_range(0, DEPTH - 1) * 4;
      xfer(1, 1'b1, a, $urandom, $sformatf("alt%0d_wr", i));
      xfer(1, 1'b0, a, 32'h0,    $sformatf("alt%0d_rd", i));
    end
    go_idle(1);

    // Asynchronous reset in the middle of a completing access.
    xfer(1, 1'b1, 32'h20, 32'h12345678, "rstm_pre");
    @(negedge clk);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b0; paddr[1] = 32'h20;
    @(negedge clk);
    penable[1] = 1'b1;
    #1 check("rstm_before", {31'b0, pready[1]}, 32'h1);
    check("rstm_before_rd", prdata[1], 32'h12345678);
    #1 rst_n = 1'b0;
    #1 check("rstm_ready", {31'b0, pready[1]}, 32'h0);
    check("rstm_rdata", prdata[1], 32'h0);
    check("rstm_err", {31'b0, pslverr[1]}, 32'h0);
    clear_model();
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    xfer(1, 1'b0, 32'h20, 32'h0, "post_rst_b20");
    xfer(1, 1'b0, 32'h00, 32'h0, "post_rst_b00");
    go_idle(1);
    xfer(0, 1'b0, 32'h08, 32'h0, "post_rst_a08");
    go_idle(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_apb_slave_mem
